// File: rtl/ysyx_25020047_mem_pkg.sv
// Shared memory-side definitions for the data SRAM and the LSU handshake adapter.
// Latency: n/a (types, constants and a pure helper function).
// Backpressure: n/a.
package ysyx_25020047_mem_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_t;

  // True when addr falls in [base, base + span_bytes). The lower-bound test
  // comes first so the subtraction below can never wrap into the window.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span_bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < span_bytes);
  endfunction

endpackage

// File: rtl/ysyx_25020047_dsram_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Latency: write lands on the enabling edge; read data is valid the cycle after re.
// Backpressure: none; read data holds until the next re.
module ysyx_25020047_dsram_array
  import ysyx_25020047_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; output is held between reads so the response stays stable.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/ysyx_25020047_dsram.sv
// Handshaked data SRAM model for the LSU: one read or byte-masked write in flight.
// Latency: response valid LATENCY cycles after request acceptance.
// Backpressure: holds the response until resp_ready; no new request accepted meanwhile.
module ysyx_25020047_dsram
  import ysyx_25020047_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam int          CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_wen;
  logic [31:0]       lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [MASK_W-1:0] lat_wmask;
  logic              rd_sel;

  logic              in_range;
  logic [31:0]       off;
  logic [IDX_W-1:0]  arr_idx;
  logic              fire;
  logic              arr_we;
  logic              arr_re;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_off_bits;

  assign in_range        = addr_in_range(lat_addr, BASE_ADDR, SPAN_BYTES);
  assign off             = lat_addr - BASE_ADDR;
  assign arr_idx         = off[IDX_W+1:2];
  assign unused_off_bits = ^{off[1:0], off[31:IDX_W+2]};

  // The array fires only on the last WAIT cycle; reset on that edge cancels the access.
  assign fire   = (state == S_WAIT) && (cnt == '0) && !rst;
  assign arr_we = fire && lat_wen && in_range;
  assign arr_re = fire && !lat_wen && in_range;

  // Array read data is valid only after a successful read; writes and errors return zero.
  assign resp_rdata = rd_sel ? arr_rdata : '0;

  ysyx_25020047_dsram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (lat_wdata),
    .wmask (lat_wmask),
    .rdata (arr_rdata)
  );

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_sel     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            lat_wen   <= req_wen;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_err   <= !in_range;
            rd_sel     <= in_range && !lat_wen;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_dsram.sv
// Self-checking bench for the data SRAM: directed scenarios plus a random phase
// compared against a word-indexed memory model.
// Clock period 10; inputs driven away from the rising edge, outputs sampled on the falling edge.
module tb_ysyx_25020047_dsram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: word index -> contents, only for words whose value is known.
  logic [31:0] model [int];

  ysyx_25020047_dsram #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return (off < 0) || (off >= longint'(4 * DEPTH));
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'(d / 4);
  endfunction

  // One full transaction: issue, measure latency, optionally stall the response,
  // compare against the model, then hand back and update the model.
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask,
                     input int stall, output logic [31:0] rd, output logic er);
    int          w;
    int          lat;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        known;
    logic [31:0] nv;
    exp_err = ref_err(addr);
    exp_rd  = 32'd0;
    known   = 1'b1;
    idx     = 0;
    if (!exp_err) begin
      idx = ref_idx(addr);
      if (!wen) begin
        if (model.exists(idx)) exp_rd = model[idx];
        else known = 1'b0;
      end
    end

    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check(tag, "req_ready_idle", 32'(req_ready), 32'd1);

    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wmask  = wmask;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wmask = ~wmask;

    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (resp_valid) break;
    end
    check(tag, "latency", 32'(lat), 32'(LAT));
    check(tag, "req_ready_busy", 32'(req_ready), 32'd0);
    rd = resp_rdata;
    er = resp_err;
    check(tag, "resp_err", 32'(er), 32'(exp_err));
    if (known) check(tag, "resp_rdata", rd, exp_rd);

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check(tag, "stall_valid", 32'(resp_valid), 32'd1);
      check(tag, "stall_rdata", resp_rdata, rd);
      check(tag, "stall_err", 32'(resp_err), 32'(er));
      check(tag, "stall_req_ready", 32'(req_ready), 32'd0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check(tag, "post_valid", 32'(resp_valid), 32'd0);
    check(tag, "post_req_ready", 32'(req_ready), 32'd1);

    if (wen && !exp_err) begin
      if (model.exists(idx) || wmask == 4'hF) begin
        nv = model.exists(idx) ? model[idx] : 32'd0;
        for (int b = 0; b < 4; b++)
          if (wmask[b]) nv[8*b +: 8] = wdata[8*b +: 8];
        model[idx] = nv;
      end
    end
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_wen    = 1'b1;
    req_addr   = BASE;
    req_wdata  = 32'hFFFF_FFFF;
    req_wmask  = 4'hF;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "req_ready", 32'(req_ready), 32'd1);
    check("reset", "resp_valid", 32'(resp_valid), 32'd0);
    check("reset", "resp_rdata", resp_rdata, 32'd0);
    check("reset", "resp_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0;
    rst       = 1'b0;

    // Full-word write then read back.
    txn("wr_full", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    check("wr_full", "rdata_zero", rd, 32'd0);
    txn("rd_full", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, rd, er);
    check("rd_full", "value", rd, 32'hDEAD_BEEF);

    // Single-byte store and unaligned-address read.
    txn("byte_init", 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, rd, er);
    txn("byte_wr", 1'b1, 32'h8000_0020, 32'h00AB_0000, 4'b0100, 0, rd, er);
    txn("byte_rd", 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, rd, er);
    check("byte_rd", "value", rd, 32'h11AB_3344);
    txn("byte_rd_unal", 1'b0, 32'h8000_0022, 32'd0, 4'h0, 0, rd, er);
    check("byte_rd_unal", "value", rd, 32'h11AB_3344);

    // Out-of-range accesses on both sides of the window.
    txn("oor_init", 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, rd, er);
    txn("oor_low", 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 0, rd, er);
    check("oor_low", "err", 32'(er), 32'd1);
    txn("oor_high", 1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 0, rd, er);
    check("oor_high", "err", 32'(er), 32'd1);
    txn("oor_last_ok", 1'b1, 32'h8000_3FFC, 32'hA5A5_0001, 4'hF, 0, rd, er);
    txn("oor_word0", 1'b0, 32'h8000_0000, 32'd0, 4'h0, 0, rd, er);
    check("oor_word0", "value", rd, 32'h0BAD_F00D);

    // Response back-pressure.
    txn("bp", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 5, rd, er);
    check("bp", "value", rd, 32'hDEAD_BEEF);

    // Reset while a write waits: the write must be dropped.
    txn("rst_init", 1'b1, 32'h8000_0040, 32'h0000_0000, 4'hF, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0040;
    req_wdata = 32'hCAFE_F00D;
    req_wmask = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid", "in_wait_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid", "req_ready", 32'(req_ready), 32'd1);
    check("rst_mid", "resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid", "resp_rdata", resp_rdata, 32'd0);
    check("rst_mid", "resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid", "no_spurious_valid", 32'(resp_valid), 32'd0);
    txn("rst_rd", 1'b0, 32'h8000_0040, 32'd0, 4'h0, 0, rd, er);
    check("rst_rd", "value", rd, 32'h0000_0000);

    // Empty-mask write changes nothing.
    txn("m0_init", 1'b1, 32'h8000_0050, 32'h55AA_55AA, 4'hF, 0, rd, er);
    txn("m0_wr", 1'b1, 32'h8000_0050, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    check("m0_wr", "err", 32'(er), 32'd0);
    txn("m0_rd", 1'b0, 32'h8000_0050, 32'd0, 4'h0, 0, rd, er);
    check("m0_rd", "value", rd, 32'h55AA_55AA);

    // Random traffic over a small window plus stray out-of-range addresses.
    for (int k = 0; k < 8; k++)
      txn("rnd_init", 1'b1, BASE + 32'h100 + 32'(k * 4), $urandom, 4'hF, 0, rd, er);
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [31:0] r;
      logic [3:0]  m;
      r = $urandom;
      m = r[3:0];
      case ($urandom_range(0, 7))
        0:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4096));
        1:       a = BASE - 32'($urandom_range(1, 4096));
        default: a = BASE + 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      endcase
      txn("rnd", 1'($urandom_range(0, 1)), a, $urandom, m,
          $urandom_range(0, 2), rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
